ppl_pix_writer: RTL and testbench

- Stage directly downstream of the ray-casting pipeline top.
- Consumes its per-pixel results (valid, pixel_addr_out, texture_addr) and fetches the texel from the synchronous texture ROM.
- Buffers {pixel address, colour} pairs in a small FIFO and drains them to the framebuffer write port over a valid/ready handshake.
- Raises a hold request under back-pressure and pulses frame_done when the last pixel of a frame has been written.

---
 rtl/ppl_pkg.sv | 24 ++
 rtl/ppl_pix_writer_if.sv | 29 ++
 rtl/ppl_sync_fifo.sv | 53 +++++
 rtl/ppl_pix_writer.sv | 160 ++++++++++++++++
 tb/tb_ppl_pix_writer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ppl_pkg.sv
// Shared definitions for the pixel writer stage: bus widths, the ray-miss
// texel code and the framebuffer write FSM encoding.
package ppl_pkg;

    localparam int PIX_ADDR_W = 20;
    localparam int TEX_ADDR_W = 13;
    localparam int COLOR_W    = 16;

    // Texel address the ray caster emits when a ray hits nothing.
    localparam logic [TEX_ADDR_W-1:0] TEX_MISS = 13'h1FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } wr_state_e;

    // One write-buffer entry: address in the upper bits, RGB565 below.
    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]    color;
    } fb_entry_t;

endpackage

// File: rtl/ppl_pix_writer_if.sv
// Pixel writer bus: pipeline results in, texture ROM port, framebuffer
// write port and status. master = surrounding system, slave = writer.
interface ppl_pix_writer_if;
    import ppl_pkg::*;

    logic                  in_valid;
    logic [PIX_ADDR_W-1:0] in_pixel_addr;
    logic [TEX_ADDR_W-1:0] in_texture_addr;
    logic [TEX_ADDR_W-1:0] tex_rd_addr;
    logic [COLOR_W-1:0]    tex_rd_data;
    logic                  fb_wr_en;
    logic                  fb_wr_ready;
    logic [PIX_ADDR_W-1:0] fb_wr_addr;
    logic [COLOR_W-1:0]    fb_wr_data;
    logic                  ppl_hold;
    logic                  overflow;
    logic                  frame_done;

    modport master (
        output in_valid, in_pixel_addr, in_texture_addr, tex_rd_data, fb_wr_ready,
        input  tex_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data, ppl_hold, overflow, frame_done
    );

    modport slave (
        input  in_valid, in_pixel_addr, in_texture_addr, tex_rd_data, fb_wr_ready,
        output tex_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data, ppl_hold, overflow, frame_done
    );

endinterface

// File: rtl/ppl_sync_fifo.sv
// Show-ahead synchronous FIFO. dout is the head entry whenever !empty.
// A push while full is accepted only if a pop happens in the same cycle.
module ppl_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                     clk_ppl,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_ppl) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ppl_pix_writer.sv
// Pixel writer: fetches the texel for each ray-cast pixel, queues
// {addr, colour} and drains it to the framebuffer over valid/ready.
// Optional sky fill for ray misses is built when PPL_SKY_FILL_EN is defined.
module ppl_pix_writer
    import ppl_pkg::*;
#(
    parameter int          H_DISP     = 1280,
    parameter int          V_DISP     = 720,
    parameter int          TEX_LAT    = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] SKY_COLOR  = 16'h867D
) (
    input  logic              clk_ppl,
    input  logic              rst,
    ppl_pix_writer_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PIX_ADDR_W-1:0] FB_END    = PIX_ADDR_W'(H_DISP * V_DISP);
    localparam logic [PIX_ADDR_W-1:0] LAST_ADDR = PIX_ADDR_W'(H_DISP * V_DISP - 1);
    // In-flight reads plus one cycle for hold to reach upstream.
    localparam logic [CW-1:0] HOLD_TH = CW'(FIFO_DEPTH - TEX_LAT - 2);

    // Delay line travelling alongside the ROM read.
    logic [TEX_LAT-1:0]                 vld_pipe;
    logic [TEX_LAT-1:0][PIX_ADDR_W-1:0] addr_pipe;
    logic [TEX_ADDR_W-1:0]              tex_addr_q;

    logic                  fifo_push;
    logic                  fifo_pop;
    fb_entry_t             fifo_din;
    fb_entry_t             head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [COLOR_W-1:0]    push_color;

    logic                  hold_q;
    logic                  ovf_q;
    wr_state_e             state_q, state_d;
    logic                  wr_en;
    logic                  done;
    logic                  head_ok;
    logic                  more;

    // Register the texel address and shift the pixel context down the line.
    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) begin
            tex_addr_q <= '0;
            vld_pipe   <= '0;
            addr_pipe  <= '0;
        end else begin
            if (bus.in_valid) tex_addr_q <= bus.in_texture_addr;
            vld_pipe[0]  <= bus.in_valid;
            addr_pipe[0] <= bus.in_pixel_addr;
            for (int i = 1; i < TEX_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

`ifdef PPL_SKY_FILL_EN
    logic [TEX_LAT-1:0] sky_pipe;

    // Sky flag rides the delay line so the miss colour replaces ROM data.
    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) begin
            sky_pipe <= '0;
        end else begin
            sky_pipe[0] <= bus.in_valid && (bus.in_texture_addr == TEX_MISS);
            for (int i = 1; i < TEX_LAT; i++) sky_pipe[i] <= sky_pipe[i-1];
        end
    end

    assign push_color = sky_pipe[TEX_LAT-1] ? SKY_COLOR : bus.tex_rd_data;
`else
    assign push_color = bus.tex_rd_data;
`endif

    assign fifo_push      = vld_pipe[TEX_LAT-1];
    assign fifo_din.addr  = addr_pipe[TEX_LAT-1];
    assign fifo_din.color = push_color;

    ppl_sync_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_ppl (clk_ppl),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Registered hold request and sticky drop flag.
    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) begin
            hold_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            hold_q <= (fifo_count >= HOLD_TH);
            if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign head_ok = (head.addr < FB_END);
    // Entry still present after this cycle's pop (a same-cycle push always lands).
    assign more    = (fifo_count > CW'(1)) || fifo_push;

    // Write FSM next state and framebuffer port drive.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = SEND;
            end
            SEND: begin
                if (!head_ok) begin
                    // Off-screen address: discard without a bus cycle.
                    fifo_pop = 1'b1;
                    state_d  = more ? SEND : IDLE;
                end else begin
                    wr_en = 1'b1;
                    if (bus.fb_wr_ready) begin
                        fifo_pop = 1'b1;
                        if (head.addr == LAST_ADDR) state_d = DONE;
                        else                        state_d = more ? SEND : IDLE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = fifo_empty ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tex_rd_addr = tex_addr_q;
    assign bus.fb_wr_en    = wr_en;
    assign bus.fb_wr_addr  = wr_en ? head.addr  : '0;
    assign bus.fb_wr_data  = wr_en ? head.color : '0;
    assign bus.ppl_hold    = hold_q;
    assign bus.overflow    = ovf_q;
    assign bus.frame_done  = done;

endmodule

// File: tb/tb_ppl_pix_writer.sv
// Bench for ppl_pix_writer: a scoreboard queue receives the expected
// {addr, colour} when a pixel is driven; a negedge monitor pops and compares
// on each framebuffer handshake. Honours PPL_SKY_FILL_EN like the RTL.
module tb_ppl_pix_writer;

    localparam int TEX_LAT    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam logic [19:0] LAST = 20'd921599;
    localparam logic [19:0] FBN  = 20'd921600;

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    int   wr_cnt = 0;
    int   fd_cnt = 0;
    bit   sb_en  = 1'b1;
    exp_t exp_q[$];

    bit          prev_last  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [19:0] prev_addr  = '0;
    logic [15:0] prev_data  = '0;

    ppl_pix_writer_if bus ();

    ppl_pix_writer #(
        .H_DISP     (1280),
        .V_DISP     (720),
        .TEX_LAT    (TEX_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SKY_COLOR  (16'h867D)
    ) dut (
        .clk_ppl (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [12:0] a);
        if (a == 13'h0040) return 16'hF800;
        return {a, 3'b000} ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] exp_col(input logic [12:0] t);
`ifdef PPL_SKY_FILL_EN
        if (t == 13'h1FFF) return 16'h867D;
`endif
        return rom_f(t);
    endfunction

    // ROM model: data lands TEX_LAT cycles after the pixel is sampled.
    always @(posedge clk) bus.tex_rd_data <= rom_f(bus.tex_rd_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [19:0] a, input logic [12:0] t);
        bus.in_valid        = 1'b1;
        bus.in_pixel_addr   = a;
        bus.in_texture_addr = t;
        if (sb_en && a < FBN) exp_q.push_back('{a: a, c: exp_col(t)});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int c = 0;
        while ((exp_q.size() != 0 || bus.fb_wr_en) && c < bound) begin
            tick();
            c++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard compare, frame_done timing, stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_last  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stable_addr", bus.fb_wr_addr, prev_addr);
                chk("stable_data", bus.fb_wr_data, prev_data);
            end
            if (bus.frame_done || prev_last) chk("frame_done", bus.frame_done, prev_last);
            if (bus.frame_done) fd_cnt++;
            if (bus.fb_wr_en && bus.fb_wr_ready) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_unexp", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.fb_wr_addr, e.a);
                    chk("wr_data", bus.fb_wr_data, e.c);
                end
            end
            prev_last  = bus.fb_wr_en && bus.fb_wr_ready && (bus.fb_wr_addr == LAST);
            prev_stall = bus.fb_wr_en && !bus.fb_wr_ready;
            prev_addr  = bus.fb_wr_addr;
            prev_data  = bus.fb_wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n, cyc, w0, f0;
        bus.in_valid        = 1'b0;
        bus.in_pixel_addr   = '0;
        bus.in_texture_addr = '0;
        bus.fb_wr_ready     = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_en",    bus.fb_wr_en,    0);
        chk("rst_hold",  bus.ppl_hold,    0);
        chk("rst_ovf",   bus.overflow,    0);
        chk("rst_fd",    bus.frame_done,  0);
        chk("rst_taddr", bus.tex_rd_addr, 0);
        chk("rst_waddr", bus.fb_wr_addr,  0);
        rst = 1'b0;
        tick(); tick();

        // Single pixel: write appears TEX_LAT+2 cycles after input
        bus.fb_wr_ready = 1'b1;
        send(20'h00010, 13'h0040);
        lat = 1;
        while (!bus.fb_wr_en && lat < 20) begin
            tick();
            lat++;
        end
        chk("lat", lat, TEX_LAT + 2);
        chk("lat_addr", bus.fb_wr_addr, 20'h00010);
        chk("lat_data", bus.fb_wr_data, 16'hF800);
        drain(50);

        // Back-pressure: upstream honours hold
        bus.fb_wr_ready = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 300) begin
            if (!bus.ppl_hold) begin
                send(20'd100 + 20'(n), 13'(n + 1));
                n++;
            end else begin
                tick();
            end
            cyc++;
            if (cyc == 30) begin
                chk("bp_issued", n, 7);
                chk("bp_hold", bus.ppl_hold, 1);
                chk("bp_ovf", bus.overflow, 0);
                bus.fb_wr_ready = 1'b1;
            end
        end
        chk("bp_sent", n, 16);
        drain(200);
        chk("bp_ovf_end", bus.overflow, 0);

        // Frame end: last pixel, then an off-screen one, then a normal one
        f0 = fd_cnt;
        w0 = wr_cnt;
        send(LAST, 13'd3);
        send(FBN, 13'd4);
        send(20'd5, 13'd6);
        drain(50);
        repeat (4) tick();
        chk("fd_cnt", fd_cnt - f0, 1);
        chk("fe_writes", wr_cnt - w0, 2);

        // Overflow: ignore hold, 12 pixels into an 8-entry buffer
        bus.fb_wr_ready = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 12; i++) begin
            sb_en = (i < FIFO_DEPTH);
            send(20'd200 + 20'(i), 13'(i + 40));
        end
        sb_en = 1'b1;
        repeat (6) tick();
        chk("ovf_set", bus.overflow, 1);
        bus.fb_wr_ready = 1'b1;
        drain(100);
        repeat (4) tick();
        chk("ovf_writes", wr_cnt - w0, FIFO_DEPTH);
        chk("ovf_sticky", bus.overflow, 1);

        // Reset mid-operation with 5 entries queued
        bus.fb_wr_ready = 1'b0;
        sb_en = 1'b0;
        for (int i = 0; i < 5; i++) send(20'd300 + 20'(i), 13'(i + 60));
        sb_en = 1'b1;
        repeat (6) tick();
        chk("mrst_pre_en",   bus.fb_wr_en, 1);
        chk("mrst_pre_hold", bus.ppl_hold, 1);
        rst = 1'b1;
        #1;
        chk("mrst_en",   bus.fb_wr_en, 0);
        chk("mrst_hold", bus.ppl_hold, 0);
        chk("mrst_ovf",  bus.overflow, 0);
        tick(); tick();
        rst = 1'b0;
        w0 = wr_cnt;
        bus.fb_wr_ready = 1'b1;
        repeat (20) tick();
        chk("mrst_no_wr", wr_cnt - w0, 0);

        // Ray miss texel: sky colour when the fill is built, ROM data otherwise
        send(20'd7, 13'h1FFF);
        send(20'd8, 13'h0010);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
